// File: rtl/router_pkt_src.sv
// router_pkt_src -- packet source for one router input port.
//
// A start request in IDLE latches a destination, a payload length and an LFSR
// seed. The block then sends one packet: a header byte, payload_len LFSR
// bytes, and a trailing parity byte. Each byte moves on a rising edge where
// busy is low. While busy is high the current byte and all internal state hold.
//
// Optional feature: define PARITY_CORRUPT_EN to add the corrupt_parity input.
// When corrupt_parity is latched high at start, the parity byte sent on the
// wire is inverted in bit 0. The internal parity accumulator is unaffected.
//
// Ports:
//   clk            clock; all state updates on its rising edge
//   resetn         synchronous active-low reset
//   start          request one packet (only looked at in IDLE)
//   dest_addr[1:0] destination port, 0..2 (3 is rejected)
//   payload_len[5:0] payload byte count, 1..63 (0 is rejected)
//   seed[7:0]      first payload byte (0 is replaced by 1)
//   busy           router stall; no byte moves on an edge with busy=1
//   corrupt_parity (PARITY_CORRUPT_EN only) send parity^1 for this packet
//   pkt_valid      high while the header or a payload byte is presented
//   data_out[7:0]  header, payload or parity byte; 0 otherwise
//   tx_active      high from HEADER through DONE
//   done           one-cycle pulse in DONE
//   cfg_err        one-cycle pulse after a rejected start
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start; all outputs 0
// HEADER  | presenting {payload_len, dest_addr}
// PAYLOAD | presenting the current LFSR byte; cnt_q bytes remain
// PARITY  | presenting the XOR of the header and all payload bytes
// DONE    | one-cycle done pulse; returns to IDLE
module router_pkt_src (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] payload_len,
  input  logic [7:0] seed,
  input  logic       busy,
`ifdef PARITY_CORRUPT_EN
  input  logic       corrupt_parity,
`endif
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_active,
  output logic       done,
  output logic       cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_PARITY  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  dest_q;
  logic [5:0]  len_q;
  logic [5:0]  cnt_q;
  logic [7:0]  lfsr_q;
  logic [7:0]  parity_q;
  logic        cfg_err_q;
  logic        start_ok;
  logic        start_bad;
  logic [7:0]  header;
  logic [7:0]  lfsr_next;
  logic [7:0]  parity_tx;

  assign header    = {len_q, dest_q};
  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign cfg_err   = cfg_err_q;

`ifdef PARITY_CORRUPT_EN
  logic corrupt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      corrupt_q <= 1'b0;
    end else if (start_ok) begin
      corrupt_q <= corrupt_parity;
    end
  end

  assign parity_tx = parity_q ^ {7'd0, corrupt_q};
`else
  assign parity_tx = parity_q;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pkt_valid = 1'b0;
    data_out  = 8'd0;
    tx_active = 1'b1;
    done      = 1'b0;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_active = 1'b0;
        if (start) begin
          if (payload_len == 6'd0 || dest_addr == 2'd3) begin
            start_bad = 1'b1;
          end else begin
            start_ok = 1'b1;
            state_d  = S_HEADER;
          end
        end
      end
      S_HEADER: begin
        pkt_valid = 1'b1;
        data_out  = header;
        if (!busy) state_d = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        pkt_valid = 1'b1;
        data_out  = lfsr_q;
        // cnt_q counts the bytes still to send, including the one on the bus
        if (!busy && cnt_q <= 6'd1) state_d = S_PARITY;
      end
      S_PARITY: begin
        data_out = parity_tx;
        if (!busy) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        tx_active = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dest_q    <= 2'd0;
      len_q     <= 6'd0;
      cnt_q     <= 6'd0;
      lfsr_q    <= 8'd0;
      parity_q  <= 8'd0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= start_bad;
      if (start_ok) begin
        dest_q   <= dest_addr;
        len_q    <= payload_len;
        cnt_q    <= payload_len;
        // an all-zero LFSR would lock up, so a zero seed starts at 1
        lfsr_q   <= (seed == 8'd0) ? 8'd1 : seed;
        parity_q <= 8'd0;
      end
      if (state_q == S_HEADER && !busy) begin
        parity_q <= parity_q ^ header;
      end
      if (state_q == S_PAYLOAD && !busy) begin
        parity_q <= parity_q ^ lfsr_q;
        lfsr_q   <= lfsr_next;
        if (cnt_q != 6'd0) cnt_q <= cnt_q - 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_src.sv
// Self-checking bench for router_pkt_src. Stimulus pushes the expected packet
// (header, payload bytes, parity, done marker) into a queue; a negedge monitor
// pops one entry for every byte the DUT transfers and compares it.
module tb_router_pkt_src;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dest_addr = 2'd0;
  logic [5:0] payload_len = 6'd0;
  logic [7:0] seed = 8'd0;
  logic       busy = 1'b0;
`ifdef PARITY_CORRUPT_EN
  logic       corrupt_parity = 1'b0;
`endif
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_active;
  logic       done;
  logic       cfg_err;

  router_pkt_src dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .dest_addr   (dest_addr),
    .payload_len (payload_len),
    .seed        (seed),
    .busy        (busy),
`ifdef PARITY_CORRUPT_EN
    .corrupt_parity (corrupt_parity),
`endif
    .pkt_valid   (pkt_valid),
    .data_out    (data_out),
    .tx_active   (tx_active),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  // kind: 0 = byte with pkt_valid=1, 1 = parity byte, 2 = done cycle
  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] last_parity = 8'd0;
  logic [7:0] first_payload = 8'd0;
  int         pkt_pos = 0;
  int         n_valid = 0;
  int         c02;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference packet: header, LFSR payload, XOR parity, done marker.
  task automatic push_packet(input logic [1:0] d, input logic [5:0] l,
                             input logic [7:0] s, input bit corrupt);
    logic [7:0] b;
    logic [7:0] p;
    exp_t       e;
    e.kind = 0; e.data = {l, d};
    sb.push_back(e);
    p = {l, d};
    b = (s == 8'd0) ? 8'd1 : s;
    for (int i = 0; i < int'(l); i++) begin
      e.kind = 0; e.data = b;
      sb.push_back(e);
      p = p ^ b;
      b = {b[6:0], ^(b & 8'hB8)};
    end
    e.kind = 1; e.data = corrupt ? (p ^ 8'h01) : p;
    sb.push_back(e);
    e.kind = 2; e.data = 8'd0;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_underflow_done actual=done required=no_done");
      end else begin
        e = sb.pop_front();
        check("done_kind", e.kind, 2);
        check("done_data", data_out, 0);
        check("done_valid", pkt_valid, 0);
        check("done_tx_active", tx_active, 1);
      end
      pkt_pos = 0;
    end else if (tx_active && !busy) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_underflow actual=%0h required=no_byte", data_out);
      end else begin
        e = sb.pop_front();
        check("byte_valid", pkt_valid, (e.kind == 0));
        check("byte_data", data_out, e.data);
        if (e.kind == 1) last_parity = data_out;
        if (pkt_valid) n_valid++;
        if (pkt_pos == 1) first_payload = data_out;
        pkt_pos++;
      end
    end else if (!tx_active) begin
      check("idle_valid", pkt_valid, 0);
      check("idle_data", data_out, 0);
      check("idle_done", done, 0);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_pkt_valid"}, pkt_valid, 0);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_tx_active"}, tx_active, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  // Called at posedge+1 with the DUT in IDLE. Random start/config is driven
  // while the packet is active to show it is ignored.
  task automatic run_pkt(input logic [1:0] d, input logic [5:0] l, input logic [7:0] s,
                         input int busy_pct, input int stall_lo, input int stall_hi,
                         input int abort_at, input bit corrupt, output int cnt02);
    bit fin;
    push_packet(d, l, s, corrupt);
    n_valid = 0;
    pkt_pos = 0;
    cnt02 = 0;
    fin = 1'b0;
    resetn = 1'b1;
    start = 1'b1;
    dest_addr = d;
    payload_len = l;
    seed = s;
    busy = 1'b0;
`ifdef PARITY_CORRUPT_EN
    corrupt_parity = corrupt;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    check("start_taken", tx_active, 1);
    for (int i = 0; i < 4000 && !fin; i++) begin
      if (pkt_valid && data_out == 8'h02) cnt02++;
      if (i == abort_at) begin
        resetn = 1'b0;
        busy = 1'b0;
        @(posedge clk); #1;
        check_all_zero("abort");
        sb.delete();
        resetn = 1'b1;
        return;
      end
      busy = (i >= stall_lo && i <= stall_hi) ? 1'b1 : (int'($urandom_range(99)) < busy_pct);
      start = 1'($urandom_range(1));
      dest_addr = 2'($urandom_range(3));
      payload_len = 6'($urandom_range(63));
      seed = 8'($urandom_range(255));
`ifdef PARITY_CORRUPT_EN
      corrupt_parity = 1'($urandom_range(1));
`endif
      @(posedge clk); #1;
      if (!tx_active) fin = 1'b1;
    end
    start = 1'b0;
    busy = 1'b0;
    if (!fin) begin
      checks++; failures++;
      $display("FAIL pkt_timeout actual=still_active required=done_within_4000");
    end
    check("sb_drained", sb.size(), 0);
    check("valid_bytes", n_valid, int'(l) + 1);
  endtask

  task automatic bad_start(input logic [1:0] d, input logic [5:0] l);
    start = 1'b1;
    dest_addr = d;
    payload_len = l;
    seed = 8'($urandom_range(255));
    @(posedge clk); #1;
    start = 1'b0;
    check("bad_cfg_err", cfg_err, 1);
    check("bad_tx_active", tx_active, 0);
    check("bad_pkt_valid", pkt_valid, 0);
    @(posedge clk); #1;
    check("bad_cfg_err_pulse", cfg_err, 0);
    check("bad_still_idle", tx_active, 0);
  endtask

  initial begin
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");

    // basic packet; start driven on the same cycle reset is released
    run_pkt(2'd1, 6'd4, 8'h01, 0, -1, -1, -1, 1'b0, c02);
    check("basic_parity", last_parity, 8'h1E);

    // stall on payload byte 8'h02 for two cycles
    run_pkt(2'd1, 6'd4, 8'h01, 0, 2, 3, -1, 1'b0, c02);
    check("stall_hold_02", c02, 3);
    check("stall_parity", last_parity, 8'h1E);

    bad_start(2'd1, 6'd0);
    bad_start(2'd3, 6'd5);

    // reset during the 3rd payload byte, then a fresh packet
    run_pkt(2'd2, 6'd18, 8'($urandom_range(255)), 0, -1, -1, 3, 1'b0, c02);
    run_pkt(2'd0, 6'd18, 8'($urandom_range(255)), 20, -1, -1, -1, 1'b0, c02);

    // zero seed, maximum length
    run_pkt(2'd0, 6'd63, 8'h00, 0, -1, -1, -1, 1'b0, c02);
    check("seed0_first_payload", first_payload, 8'h01);

`ifdef PARITY_CORRUPT_EN
    run_pkt(2'd1, 6'd4, 8'h01, 0, -1, -1, -1, 1'b1, c02);
    check("corrupt_parity", last_parity, 8'h1F);
`endif

    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(3) == 0) begin
        if ($urandom_range(1) == 0) bad_start(2'($urandom_range(3)), 6'd0);
        else bad_start(2'd3, 6'($urandom_range(63)));
      end
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
      run_pkt(2'($urandom_range(2)), 6'($urandom_range(63, 1)), 8'($urandom_range(255)),
              30, -1, -1, -1, 1'($urandom_range(1)) & 1'b0, c02);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_pkt_src.md
ROUTER_PKT_SRC -- requirements
Module: router_pkt_src

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset (`clk`, `resetn`); all state SHALL update on the rising edge of `clk`.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- start  in  1  request to send one packet; sampled only in IDLE
- dest_addr  in  2  destination port, valid values 0..2
- payload_len  in  6  payload byte count, valid values 1..63
- seed  in  8  LFSR seed for payload bytes
- busy  in  1  router stall; byte not accepted on an edge where busy=1
- pkt_valid  out  1  high during header and payload bytes
- data_out  out  8  header, payload or parity byte
- tx_active  out  1  high from HEADER through DONE
- done  out  1  one-cycle pulse in DONE
- cfg_err  out  1  one-cycle pulse when start is rejected

Function
REQ-003 States SHALL be IDLE, HEADER, PAYLOAD, PARITY and DONE.
REQ-004 In IDLE, on start=1 with a valid config, the block SHALL latch dest_addr, payload_len and seed, and enter HEADER on the next edge (1-cycle latency).
REQ-005 If payload_len=0 or dest_addr=2'b11 at start, the block SHALL stay in IDLE and pulse cfg_err for 1 cycle.
REQ-006 A byte SHALL be transferred on a rising edge where busy=0; while busy=1 the block SHALL hold state, data_out, pkt_valid and all counters unchanged.
REQ-007 HEADER SHALL drive pkt_valid=1 and data_out={payload_len,dest_addr}; on transfer it SHALL go to PAYLOAD.
REQ-008 PAYLOAD SHALL drive pkt_valid=1 with the current LFSR byte, and SHALL go to PARITY after payload_len bytes have transferred.
REQ-009 The first payload byte SHALL be the seed, with seed 8'h00 replaced by 8'h01.
REQ-010 Each later payload byte SHALL be {s[6:0], s[7]^s[5]^s[4]^s[3]} of the previous byte.
REQ-011 The parity register SHALL clear at start and XOR in the header and every payload byte on transfer.
REQ-012 PARITY SHALL drive pkt_valid=0 and data_out=parity; on transfer it SHALL go to DONE.
REQ-013 DONE SHALL last exactly 1 cycle with done=1, pkt_valid=0 and data_out=0, then return to IDLE; there is a minimum 1-cycle gap between packets.
REQ-014 start SHALL be ignored in any state other than IDLE; start=1 in DONE is not remembered.
REQ-015 In IDLE, pkt_valid, data_out, tx_active and done SHALL all be 0.
REQ-016 The payload counter SHALL be 6 bits, count down from the latched length, and never wrap below 0.

Reset
REQ-017 resetn=0 at a rising edge SHALL force IDLE and clear pkt_valid, data_out, tx_active, done, cfg_err, counter, parity and LFSR to 0, including mid-packet; the aborted packet is not resumed.
REQ-018 The first start SHALL be honoured on the first edge after resetn returns to 1.

Configuration
REQ-019 With `PARITY_CORRUPT_EN` defined, the block SHALL add input `corrupt_parity` (1 bit), latch it at start, and when it is latched as 1 SHALL send parity^8'h01 in PARITY. The internal parity register is unchanged.
REQ-020 Without `PARITY_CORRUPT_EN`, the port SHALL be absent and the correct parity SHALL always be sent.

Verification
REQ-021 Basic packet: start, dest_addr=1, payload_len=4, seed=8'h01, busy=0 -> data_out 8'h11, 01, 02, 04, 08 with pkt_valid=1, then 8'h1E with pkt_valid=0, then done for 1 cycle.
REQ-022 Stall: same packet with busy=1 for 2 cycles while byte 8'h02 is presented -> 8'h02 held 3 cycles, no byte skipped or duplicated, parity still 8'h1E.
REQ-023 Bad config: start with payload_len=0, then start with dest_addr=3 -> cfg_err pulses each time, pkt_valid stays 0, state stays IDLE.
REQ-024 Reset mid-operation: resetn=0 during the 3rd payload byte of an 18-byte packet -> next cycle all outputs 0; a new start then sends a complete fresh packet.
REQ-025 Seed zero and maximum length: seed=8'h00, payload_len=63 -> first payload byte 8'h01; exactly 63 payload bytes are sent and parity matches the XOR computed by the bench.
REQ-026 With `PARITY_CORRUPT_EN` and corrupt_parity=1 on the REQ-021 packet -> parity byte 8'h1F; start ignored while tx_active=1.
